muldiv_sequencer: RTL and testbench

Controls the shared iterative multiplier and divider for the EXE stage. Accepts one M-extension op per handshake and latches its operands. Issues a single-cycle valid pulse to the selected unit and captures the result on that unit's out_valid. Formats the result (sign-extends W ops) and holds it until writeback accepts it. Handles pipeline flush by draining the unit in flight, and short-circuits divide-by-zero without issuing.

---
 rtl/muldiv_sequencer_pkg.sv | 44 ++++
 rtl/muldiv_reuse_cache.sv | 55 +++++
 rtl/muldiv_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the M-extension multiply/divide sequencer:
// op codes, FSM state encoding and multiplier signedness encodings.
package muldiv_sequencer_pkg;

    localparam int unsigned DATA_W = 64;
    localparam logic [DATA_W-1:0] XLEN_ONES = {DATA_W{1'b1}};

    localparam logic [3:0] OP_MUL    = 4'b1001;
    localparam logic [3:0] OP_MULH   = 4'b0001;
    localparam logic [3:0] OP_MULHSU = 4'b0010;
    localparam logic [3:0] OP_MULHU  = 4'b0011;
    localparam logic [3:0] OP_MULW   = 4'b1000;
    localparam logic [3:0] OP_DIV    = 4'b0100;
    localparam logic [3:0] OP_DIVU   = 4'b0101;
    localparam logic [3:0] OP_REM    = 4'b0110;
    localparam logic [3:0] OP_REMU   = 4'b0111;
    localparam logic [3:0] OP_DIVW   = 4'b1100;
    localparam logic [3:0] OP_DIVUW  = 4'b1101;
    localparam logic [3:0] OP_REMW   = 4'b1110;
    localparam logic [3:0] OP_REMUW  = 4'b1111;

    localparam logic [1:0] MUL_SS = 2'b11;
    localparam logic [1:0] MUL_SU = 2'b10;
    localparam logic [1:0] MUL_UU = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StDrain
    } state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_MULHU) || (op == OP_MULW);
    endfunction

    // Every 01xx and 11xx code is a divide/remainder.
    function automatic logic is_div_op(input logic [3:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_reuse_cache.sv
// Single-entry divide result cache: remembers the operands and mode of the last
// completed divide together with both its quotient and remainder.
module muldiv_reuse_cache
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = DATA_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            store,
    input  logic [XLEN-1:0] store_src1,
    input  logic [XLEN-1:0] store_src2,
    input  logic            store_w,
    input  logic            store_signed,
    input  logic [XLEN-1:0] store_quot,
    input  logic [XLEN-1:0] store_rem,
    input  logic [XLEN-1:0] look_src1,
    input  logic [XLEN-1:0] look_src2,
    input  logic            look_w,
    input  logic            look_signed,
    output logic            hit,
    output logic [XLEN-1:0] hit_quot,
    output logic [XLEN-1:0] hit_rem
);

    logic            valid_q;
    logic [XLEN-1:0] src1_q, src2_q, quot_q, rem_q;
    logic            w_q, signed_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            w_q      <= 1'b0;
            signed_q <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
        end else if (store) begin
            valid_q  <= 1'b1;
            src1_q   <= store_src1;
            src2_q   <= store_src2;
            w_q      <= store_w;
            signed_q <= store_signed;
            quot_q   <= store_quot;
            rem_q    <= store_rem;
        end
    end

    assign hit = valid_q && (src1_q == look_src1) && (src2_q == look_src2) &&
                 (w_q == look_w) && (signed_q == look_signed);
    assign hit_quot = quot_q;
    assign hit_rem  = rem_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared iterative multiplier/divider in EXE. Optional divide
// result reuse is enabled with the MULDIV_DIVREM_REUSE_EN macro.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = DATA_W,
    parameter int unsigned OP_W = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy,
    output logic            mul_valid,
    input  logic            mul_ready,
    output logic            mulw,
    output logic [1:0]      mul_signed,
    input  logic            mul_out_valid,
    input  logic [XLEN-1:0] mul_result_hi,
    input  logic [XLEN-1:0] mul_result_lo,
    output logic            div_valid,
    input  logic            div_ready,
    output logic            divw,
    output logic            div_signed,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder,
    output logic [XLEN-1:0] unit_src1,
    output logic [XLEN-1:0] unit_src2
);

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q;
    logic [XLEN-1:0] src1_q, src2_q, result_q;

    logic            accept, capture, req_w, req_zero;
    logic            cur_is_mul, cur_is_div, unit_ready, unit_out_valid;
    logic [XLEN-1:0] zero_result, unit_result, div_pick;
    logic            cache_hit;
    logic [XLEN-1:0] cache_result;

    assign accept      = (state_q == StIdle) && req_valid && !flush;
    assign req_w       = req_op[3];
    assign req_zero    = req_w ? (req_src2[31:0] == 32'd0) : (req_src2 == '0);
    assign zero_result = req_op[1] ? (req_w ? sext_w(req_src1) : req_src1)
                                   : XLEN_ONES[XLEN-1:0];

    assign cur_is_mul     = is_mul_op(op_q);
    assign cur_is_div     = is_div_op(op_q);
    assign unit_ready     = cur_is_mul ? mul_ready : div_ready;
    assign unit_out_valid = cur_is_mul ? mul_out_valid : div_out_valid;
    assign capture        = (state_q == StWait) && !flush && unit_out_valid;

    assign div_pick = op_q[1] ? div_remainder : div_quotient;

    always_comb begin
        unit_result = '0;
        if (cur_is_mul) begin
            if (op_q == OP_MUL)       unit_result = mul_result_lo;
            else if (op_q == OP_MULW) unit_result = sext_w(mul_result_lo);
            else                      unit_result = mul_result_hi;
        end else begin
            unit_result = op_q[3] ? sext_w(div_pick) : div_pick;
        end
    end

`ifdef MULDIV_DIVREM_REUSE_EN
    logic [XLEN-1:0] hit_quot, hit_rem, hit_pick;

    muldiv_reuse_cache #(
        .XLEN(XLEN)
    ) u_reuse_cache (
        .clock       (clock),
        .reset       (reset),
        .store       (capture && cur_is_div),
        .store_src1  (src1_q),
        .store_src2  (src2_q),
        .store_w     (op_q[3]),
        .store_signed(!op_q[0]),
        .store_quot  (div_quotient),
        .store_rem   (div_remainder),
        .look_src1   (req_src1),
        .look_src2   (req_src2),
        .look_w      (req_w),
        .look_signed (!req_op[0]),
        .hit         (cache_hit),
        .hit_quot    (hit_quot),
        .hit_rem     (hit_rem)
    );

    assign hit_pick     = req_op[1] ? hit_rem : hit_quot;
    assign cache_result = req_w ? sext_w(hit_pick) : hit_pick;
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mul_op(req_op)) begin
                        state_d = StIssue;
                    end else if (is_div_op(req_op) && !req_zero && !cache_hit) begin
                        state_d = StIssue;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StIssue: begin
                if (flush)           state_d = StIdle;
                else if (unit_ready) state_d = StWait;
            end
            StWait: begin
                // A result arriving alongside the flush is already drained.
                if (flush)               state_d = unit_out_valid ? StIdle : StDrain;
                else if (unit_out_valid) state_d = StResp;
            end
            StResp: begin
                if (flush || resp_ready) state_d = StIdle;
            end
            StDrain: begin
                if (unit_out_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == StIdle);
        busy       = (state_q != StIdle);
        resp_valid = (state_q == StResp);
        mul_valid  = (state_q == StIssue) && !flush && unit_ready && cur_is_mul;
        div_valid  = (state_q == StIssue) && !flush && unit_ready && cur_is_div;
        mulw       = cur_is_mul && (op_q == OP_MULW);
        mul_signed = MUL_UU;
        if (cur_is_mul) begin
            if (op_q == OP_MULHSU)     mul_signed = MUL_SU;
            else if (op_q == OP_MULHU) mul_signed = MUL_UU;
            else                       mul_signed = MUL_SS;
        end
        divw       = cur_is_div && op_q[3];
        div_signed = cur_is_div && !op_q[0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q   <= req_op;
            src1_q <= req_src1;
            src2_q <= req_src2;
            if (is_div_op(req_op) && req_zero)      result_q <= zero_result;
            else if (is_div_op(req_op) && cache_hit) result_q <= cache_result;
            else                                     result_q <= '0;
        end else if (capture) begin
            result_q <= unit_result;
        end
    end

    assign resp_data = result_q;
    assign unit_src1 = src1_q;
    assign unit_src2 = src2_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer with behavioural multiplier/divider units
// and an arithmetic reference model of the M-extension ops.
module tb_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, flush;
    logic [3:0]  req_op;
    logic [63:0] req_src1, req_src2;
    logic        resp_valid, resp_ready, busy;
    logic [63:0] resp_data;
    logic        mul_valid, mul_ready, mulw, mul_out_valid;
    logic [1:0]  mul_signed;
    logic [63:0] mul_result_hi, mul_result_lo;
    logic        div_valid, div_ready, divw, div_signed, div_out_valid;
    logic [63:0] div_quotient, div_remainder, unit_src1, unit_src2;

    muldiv_sequencer dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mulw(mulw),
        .mul_signed(mul_signed), .mul_out_valid(mul_out_valid),
        .mul_result_hi(mul_result_hi), .mul_result_lo(mul_result_lo),
        .div_valid(div_valid), .div_ready(div_ready), .divw(divw),
        .div_signed(div_signed), .div_out_valid(div_out_valid),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .unit_src1(unit_src1), .unit_src2(unit_src2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] data;
        int          pulses;
        logic [1:0]  msig;
        logic        mw;
        logic        dsig;
        logic        dw;
        logic [63:0] a;
        logic [63:0] b;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;
    int   rr_mode = 0;       // 0: always ready, 1: random, 2: held low
    int   div_lat_fixed = -1;
    bit          c_valid = 0;
    logic [63:0] c_a, c_b;
    bit          c_w, c_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [63:0] sx32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    function automatic logic [127:0] prod(input logic [63:0] a, input logic [63:0] b,
                                          input bit sa, input bit sbb);
        logic [127:0] a2, b2;
        a2 = sa  ? {{64{a[63]}}, a} : {64'd0, a};
        b2 = sbb ? {{64{b[63]}}, b} : {64'd0, b};
        return a2 * b2;
    endfunction

    function automatic void div_ref(input logic [63:0] a, input logic [63:0] b, input bit w,
                                    input bit s, output logic [63:0] q, output logic [63:0] r);
        logic [31:0] a32, b32, t;
        int          ia, ib;
        longint      la, lb;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            ia = a32;
            ib = b32;
            if (b32 == 0) begin
                q = '1; r = sx32(a);
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q = sx32(a); r = 0;
            end else if (s) begin
                t = ia / ib; q = sx32({32'd0, t});
                t = ia % ib; r = sx32({32'd0, t});
            end else begin
                t = a32 / b32; q = sx32({32'd0, t});
                t = a32 % b32; r = sx32({32'd0, t});
            end
        end else begin
            la = a;
            lb = b;
            if (b == 0) begin
                q = '1; r = a;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 0;
            end else if (s) begin
                q = la / lb; r = la % lb;
            end else begin
                q = a / b; r = a % b;
            end
        end
    endfunction

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        logic [127:0] p;
        logic [63:0]  q, r, lo;
        case (op)
            4'b1001: begin p = prod(a, b, 1, 1); return p[63:0];   end
            4'b0001: begin p = prod(a, b, 1, 1); return p[127:64]; end
            4'b0010: begin p = prod(a, b, 1, 0); return p[127:64]; end
            4'b0011: begin p = prod(a, b, 0, 0); return p[127:64]; end
            4'b1000: begin lo = a * b; return sx32(lo); end
            default: begin
                if (!op[2]) return 64'd0;
                div_ref(a, b, op[3], !op[0], q, r);
                return op[1] ? r : q;
            end
        endcase
    endfunction

    function automatic bit is_mul(input logic [3:0] op);
        return op == 4'b1001 || op == 4'b0001 || op == 4'b0010 || op == 4'b0011 ||
               op == 4'b1000;
    endfunction

    function automatic bit zero_div(input logic [3:0] op, input logic [63:0] b);
        return op[3] ? (b[31:0] == 0) : (b == 0);
    endfunction

    function automatic bit cache_hits(input logic [3:0] op, input logic [63:0] a,
                                      input logic [63:0] b);
`ifdef MULDIV_DIVREM_REUSE_EN
        return c_valid && c_a == a && c_b == b && c_w == op[3] && c_s == !op[0];
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t mk_exp(input logic [3:0] op, input logic [63:0] a,
                                    input logic [63:0] b);
        exp_t e;
        e.data = ref_result(op, a, b);
        e.a = a;
        e.b = b;
        e.msig = (op == 4'b0010) ? 2'b10 : (op == 4'b0011) ? 2'b00 : 2'b11;
        e.mw = (op == 4'b1000);
        e.dsig = !op[0];
        e.dw = op[3];
        if (is_mul(op)) e.pulses = 1;
        else if (op[2] && !zero_div(op, b) && !cache_hits(op, a, b)) e.pulses = 1;
        else e.pulses = 0;
        return e;
    endfunction

    // ---------------- behavioural units ----------------
    logic        m_busy = 0, d_busy = 0;
    int          m_cnt, d_cnt;
    assign mul_ready = !m_busy;
    assign div_ready = !d_busy;

    always @(posedge clock) begin
        logic [127:0] p;
        logic [63:0]  q, r;
        if (reset) begin
            m_busy <= 0; mul_out_valid <= 0;
            d_busy <= 0; div_out_valid <= 0;
        end else begin
            mul_out_valid <= 0;
            div_out_valid <= 0;
            if (m_busy) begin
                if (m_cnt == 0) begin m_busy <= 0; mul_out_valid <= 1; end
                else m_cnt <= m_cnt - 1;
            end else if (mul_valid) begin
                m_busy <= 1;
                m_cnt <= $urandom_range(0, 4);
                if (mulw) begin
                    p = prod(sx32(unit_src1), sx32(unit_src2), 1, 1);
                    mul_result_lo <= {32'hA5A5_A5A5, p[31:0]};
                end else begin
                    p = prod(unit_src1, unit_src2, mul_signed[1], mul_signed[0]);
                    mul_result_lo <= p[63:0];
                end
                mul_result_hi <= p[127:64];
            end
            if (d_busy) begin
                if (d_cnt == 0) begin d_busy <= 0; div_out_valid <= 1; end
                else d_cnt <= d_cnt - 1;
            end else if (div_valid) begin
                d_busy <= 1;
                d_cnt <= (div_lat_fixed >= 0) ? div_lat_fixed : $urandom_range(0, 5);
                div_ref(unit_src1, unit_src2, divw, div_signed, q, r);
                div_quotient  <= divw ? {32'hDEAD_BEEF, q[31:0]} : q;
                div_remainder <= divw ? {32'hDEAD_BEEF, r[31:0]} : r;
            end
        end
    end

    initial forever begin
        @(posedge clock);
        #2;
        resp_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (!reset) begin
            if (req_valid && req_ready && !flush) pulse_cnt = 0;
            if (mul_valid || div_valid) begin
                pulse_cnt++;
                if (sb.size() > 0) begin
                    chk("unit_src1", unit_src1, sb[0].a);
                    chk("unit_src2", unit_src2, sb[0].b);
                    if (mul_valid) chk("mul_fields", {61'd0, mulw, mul_signed},
                                       {61'd0, sb[0].mw, sb[0].msig});
                    else chk("div_fields", {62'd0, divw, div_signed},
                             {62'd0, sb[0].dw, sb[0].dsig});
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_resp", {63'd0, resp_valid}, 64'd0);
                end else begin
                    got = sb.pop_front();
                    chk("resp_data", resp_data, got.data);
                    chk("unit_pulses", 64'(pulse_cnt), 64'(got.pulses));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input bit push = 1, input bit fixed = 0,
                        input logic [63:0] fixed_val = 64'd0);
        exp_t e;
        bit   acc;
        e = mk_exp(op, a, b);
        if (fixed) e.data = fixed_val;
        if (push) begin
            sb.push_back(e);
            if (op[2] && !zero_div(op, b)) begin
                c_valid = 1; c_a = a; c_b = b; c_w = op[3]; c_s = !op[0];
            end
        end
        req_op = op; req_src1 = a; req_src2 = b; req_valid = 1;
        acc = 0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clock);
            acc = req_ready && !flush;
            @(posedge clock);
            #1;
        end
        req_valid = 0;
        chk("accept", 64'(acc), 64'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000 && sb.size() > 0; i++) @(posedge clock);
        #1;
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0: return 64'($urandom_range(0, 20));
            1: return 64'd0;
            2: return {$urandom, 32'd0};
            3: return 64'h8000_0000_0000_0000;
            4: return '1;
            5: return {32'hFFFF_FFFF, $urandom};
            6: return 64'h0000_0000_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit          drained, early, acc;
        logic [3:0]  op;
        logic [63:0] a, b;
        reset = 1; req_valid = 0; flush = 0; req_op = 0; req_src1 = 0; req_src2 = 0;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_unit_valid", {62'd0, mul_valid, div_valid}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_unit_src", unit_src1 | unit_src2, 64'd0);
        chk("rst_modes", {59'd0, mulw, mul_signed, divw, div_signed}, 64'd0);
        @(posedge clock); #1;

        send(4'b1001, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1, 1, 64'hFFFF_FFFF_FFFF_FFEB);
        send(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1, 1, 64'd1);
        wait_drain();
        send(4'b1100, 64'h8000_0000, 64'h1_0000_0000, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clock);
        chk("zero_div_latency", {63'd0, resp_valid}, 64'd1);
        @(posedge clock); #1;
        send(4'b1110, 64'h8000_0000, 64'h1_0000_0000, 1, 1, 64'hFFFF_FFFF_8000_0000);
        @(negedge clock);
        chk("zero_rem_latency", {63'd0, resp_valid}, 64'd1);
        wait_drain();

        // Flush while the divide is in flight, then a new request straight away.
        div_lat_fixed = 8;
        send(4'b0100, 64'd100, 64'd7, 0);
        for (int i = 0; i < 20 && !div_valid; i++) @(negedge clock);
        chk("flush_div_issued", {63'd0, div_valid}, 64'd1);
        repeat (3) @(posedge clock);
        #1;
        flush = 1;
        sb.push_back(mk_exp(4'b1001, 64'd3, 64'd4));
        sb[sb.size()-1].data = 64'd12;
        req_op = 4'b1001; req_src1 = 64'd3; req_src2 = 64'd4; req_valid = 1;
        @(posedge clock); #1;
        flush = 0;
        drained = 0; early = 0; acc = 0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clock);
            if (div_out_valid) drained = 1;
            if (req_ready && !drained) early = 1;
            acc = req_ready;
            @(posedge clock); #1;
        end
        req_valid = 0;
        chk("flush_accept", 64'(acc), 64'd1);
        chk("flush_ready_before_drain", 64'(early), 64'd0);
        div_lat_fixed = -1;
        wait_drain();

        // Writeback backpressure.
        rr_mode = 2;
        send(4'b1001, 64'd5, 64'd6);
        for (int i = 0; i < 30 && !resp_valid; i++) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_resp_data", resp_data, 64'd30);
            chk("bp_busy_ready", {62'd0, busy, req_ready}, 64'd2);
        end
        @(posedge clock); #1;
        rr_mode = 0;
        wait_drain();

        // Divide followed by the matching remainder.
        send(4'b0100, 64'd100, 64'd7, 1, 1, 64'd14);
        wait_drain();
        send(4'b0110, 64'd100, 64'd7, 1, 1, 64'd2);
`ifdef MULDIV_DIVREM_REUSE_EN
        @(negedge clock);
        chk("cache_hit_latency", {63'd0, resp_valid}, 64'd1);
`endif
        wait_drain();

        rr_mode = 1;
        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) != 0) begin
                a = rnd64();
                b = rnd64();
            end
            send(op, a, b);
        end
        wait_drain();
        rr_mode = 0;

        // Reset with a divide in flight.
        div_lat_fixed = 8;
        send(4'b0101, 64'd1000, 64'd3, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1;
        c_valid = 0;
        @(posedge clock); #1 reset = 0;
        div_lat_fixed = -1;
        @(negedge clock);
        chk("midop_reset", {61'd0, req_ready, busy, resp_valid}, 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
